// File: rtl/wb_port_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port.
// Define WB_PORT_ARBITER_STARVE_GUARD_EN to let src1 win after MAX_WAIT cycles held off.
module wb_port_arbiter #(
   parameter int unsigned MAX_WAIT = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             src0_valid,
   output logic             src0_ready,
   input  logic [4:0]       src0_rd,
   input  logic [31:0]      src0_data,
   input  logic             src1_valid,
   output logic             src1_ready,
   input  logic [4:0]       src1_rd,
   input  logic [31:0]      src1_data,
   output logic             we3,
   output logic [4:0]       a3,
   output logic [31:0]      wd3,
   output logic             grant_src,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int unsigned WAIT_W = 4;

   logic             force1;
   logic             hs0;
   logic             hs1;
   logic [4:0]       sel_rd;
   logic [31:0]      sel_data;

`ifdef WB_PORT_ARBITER_STARVE_GUARD_EN
   generate
      if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
         $error("wb_port_arbiter: MAX_WAIT must be in 1..15");
      end
   endgenerate

   logic [WAIT_W-1:0] wait_cnt;

   assign force1 = (wait_cnt >= WAIT_W'(MAX_WAIT));

   // Counts consecutive cycles src1 is pending but refused
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!src1_valid || hs1) begin
         wait_cnt <= '0;
      end else if (wait_cnt != {WAIT_W{1'b1}}) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end
`else
   logic unused_max_wait;

   assign unused_max_wait = ^32'(MAX_WAIT);
   assign force1          = 1'b0;
`endif

   // Readies never depend on the requester's own valid
   always_comb begin
      src0_ready = 1'b0;
      src1_ready = 1'b0;
      if (!reset) begin
         src0_ready = !(force1 && src1_valid);
         src1_ready = !src0_valid || force1;
      end
   end

   assign hs0      = src0_valid && src0_ready;
   assign hs1      = src1_valid && src1_ready;
   assign sel_rd   = hs1 ? src1_rd   : src0_rd;
   assign sel_data = hs1 ? src1_data : src0_data;

   // Write port: one cycle after the handshake; x0 writes are swallowed
   always_ff @(posedge clk) begin
      if (reset) begin
         we3       <= 1'b0;
         a3        <= '0;
         wd3       <= '0;
         grant_src <= 1'b0;
      end else begin
         we3 <= (hs0 || hs1) && (sel_rd != 5'd0);
         if (hs0 || hs1) begin
            a3        <= sel_rd;
            wd3       <= sel_data;
            grant_src <= hs1;
         end
      end
   end

   // Saturating count of cycles with both sources pending
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (src0_valid && src1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed checks of wb_port_arbiter against a behavioural model.
// Honours WB_PORT_ARBITER_STARVE_GUARD_EN the same way the design does.
module tb_wb_port_arbiter;

   localparam int unsigned MAX_WAIT = 3;

`ifdef WB_PORT_ARBITER_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        src0_valid, src1_valid;
   logic [4:0]  src0_rd, src1_rd;
   logic [31:0] src0_data, src1_data;
   logic        src0_ready, src1_ready;
   logic        we3, grant_src;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [15:0] conflict_cnt;
   logic        b_src0_ready, b_src1_ready, b_we3, b_grant_src;
   logic [4:0]  b_a3;
   logic [31:0] b_wd3;
   logic [3:0]  b_conflict_cnt;

   int vectors    = 0;
   int miscompares = 0;

   // model state
   int          m_wait;
   int          m_conf;
   int          m_conf4;
   logic        exp_r0, exp_r1, exp_we, exp_gs;
   logic [4:0]  exp_a3;
   logic [31:0] exp_wd;

   always #5 clk = ~clk;

   wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_data(src0_data),
      .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_data(src1_data),
      .we3(we3), .a3(a3), .wd3(wd3), .grant_src(grant_src), .conflict_cnt(conflict_cnt)
   );

   wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .src0_valid(src0_valid), .src0_ready(b_src0_ready), .src0_rd(src0_rd), .src0_data(src0_data),
      .src1_valid(src1_valid), .src1_ready(b_src1_ready), .src1_rd(src1_rd), .src1_data(src1_data),
      .we3(b_we3), .a3(b_a3), .wd3(b_wd3), .grant_src(b_grant_src), .conflict_cnt(b_conflict_cnt)
   );

   // Readies from the arbitration rules applied to current inputs
   function automatic void calc_ready();
      bit force1;
      force1 = GUARD && (m_wait >= int'(MAX_WAIT));
      exp_r0 = !reset && !(force1 && src1_valid);
      exp_r1 = !reset && (!src0_valid || force1);
   endfunction

   task automatic half();
      @(negedge clk);
      calc_ready();
   endtask

   // Advance one edge and apply the spec's register rules to the model
   task automatic edge_();
      bit hs0, hs1;
      @(posedge clk);
      calc_ready();
      if (reset) begin
         m_wait = 0; m_conf = 0; m_conf4 = 0;
         exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_gs = 0;
      end else begin
         hs0 = src0_valid && exp_r0;
         hs1 = src1_valid && exp_r1;
         if (hs1) begin
            exp_we = (src1_rd != 0); exp_a3 = src1_rd; exp_wd = src1_data; exp_gs = 1;
         end else if (hs0) begin
            exp_we = (src0_rd != 0); exp_a3 = src0_rd; exp_wd = src0_data; exp_gs = 0;
         end else begin
            exp_we = 0;
         end
         if (src0_valid && src1_valid) begin
            if (m_conf < 65535) m_conf++;
            if (m_conf4 < 15) m_conf4++;
         end
         if (!src1_valid || hs1) m_wait = 0;
         else if (m_wait < 15) m_wait++;
      end
      #1;
   endtask

   task automatic idle_inputs();
      src0_valid = 0; src1_valid = 0;
      src0_rd = 0; src1_rd = 0; src0_data = 0; src1_data = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      src0_valid = 1; src1_valid = 1;
      half();
      vectors++;
      if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", src0_ready, src1_ready);
      end
      edge_();
      edge_();
      vectors++;
      if ({we3, a3, wd3, grant_src, conflict_cnt} !== '0 || b_conflict_cnt !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_state: got we3=%b a3=%0d wd3=%h gs=%b cnt=%0d want all 0",
                  we3, a3, wd3, grant_src, conflict_cnt);
      end
      reset = 0;
      idle_inputs();
      edge_();
   endtask

   task automatic test_src0_only();
      src0_valid = 1; src0_rd = 5'd5; src0_data = 32'hDEADBEEF;
      half();
      vectors++;
      if (src0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL src0_ready: got %b want 1", src0_ready);
      end
      edge_();
      idle_inputs();
      vectors++;
      if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF || grant_src !== 1'b0) begin
         miscompares++;
         $display("FAIL src0_write: got we3=%b a3=%0d wd3=%h gs=%b want 1 5 deadbeef 0",
                  we3, a3, wd3, grant_src);
      end
      edge_();
      vectors++;
      if (we3 !== 1'b0 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL src0_idle: got we3=%b a3=%0d wd3=%h want 0 5 deadbeef", we3, a3, wd3);
      end
   endtask

   task automatic test_src1_only();
      src1_valid = 1; src1_rd = 5'd12; src1_data = 32'h00000042;
      half();
      vectors++;
      if (src1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL src1_ready: got %b want 1", src1_ready);
      end
      edge_();
      idle_inputs();
      vectors++;
      if (we3 !== 1'b1 || a3 !== 5'd12 || wd3 !== 32'h42 || grant_src !== 1'b1) begin
         miscompares++;
         $display("FAIL src1_write: got we3=%b a3=%0d wd3=%h gs=%b want 1 12 42 1",
                  we3, a3, wd3, grant_src);
      end
      edge_();
   endtask

   task automatic test_starvation();
      int c0;
      c0 = m_conf;
      for (int i = 0; i < 12; i++) begin
         src0_valid = 1; src1_valid = 1;
         src0_rd = 5'd1; src1_rd = 5'd2;
         src0_data = i; src1_data = 32'h100 + i;
         half();
         vectors++;
         if (src1_ready !== ((GUARD && (i % 4 == 3)) ? 1'b1 : 1'b0)
             || src0_ready !== !src1_ready) begin
            miscompares++;
            $display("FAIL starve_grant[%0d]: got r0=%b r1=%b", i, src0_ready, src1_ready);
         end
         edge_();
         vectors++;
         if (grant_src !== exp_gs || wd3 !== exp_wd || conflict_cnt !== 16'(c0 + i + 1)) begin
            miscompares++;
            $display("FAIL starve_write[%0d]: got gs=%b wd3=%h cnt=%0d want %b %h %0d",
                     i, grant_src, wd3, conflict_cnt, exp_gs, exp_wd, c0 + i + 1);
         end
      end
      idle_inputs();
      edge_();
   endtask

   task automatic test_x0();
      src0_valid = 1; src0_rd = 5'd0; src0_data = 32'hFFFFFFFF;
      half();
      vectors++;
      if (src0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL x0_ready: got %b want 1", src0_ready);
      end
      edge_();
      idle_inputs();
      vectors++;
      if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'hFFFFFFFF) begin
         miscompares++;
         $display("FAIL x0_write: got we3=%b a3=%0d wd3=%h want 0 0 ffffffff", we3, a3, wd3);
      end
      edge_();
   endtask

   task automatic test_reset_mid();
      src0_valid = 1; src1_valid = 1; src1_rd = 5'd9; src1_data = 32'h1234;
      edge_();
      src0_valid = 0;
      edge_();
      reset = 1; src1_valid = 1;
      edge_();
      vectors++;
      if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0 || conflict_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got we3=%b a3=%0d wd3=%h cnt=%0d want 0 0 0 0",
                  we3, a3, wd3, conflict_cnt);
      end
      reset = 0;
      idle_inputs();
      edge_();
      vectors++;
      if (we3 !== 1'b0 || wd3 !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid_lost: got we3=%b wd3=%h want 0 0", we3, wd3);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) begin
         src0_valid = 1; src1_valid = 1; src0_rd = 5'd3; src1_rd = 5'd4;
         edge_();
      end
      vectors++;
      if (b_conflict_cnt !== 4'd15 || conflict_cnt !== 16'(m_conf)) begin
         miscompares++;
         $display("FAIL saturate: got cnt4=%0d cnt16=%0d want 15 %0d",
                  b_conflict_cnt, conflict_cnt, m_conf);
      end
      edge_();
      vectors++;
      if (b_conflict_cnt !== 4'd15) begin
         miscompares++;
         $display("FAIL saturate_hold: got %0d want 15", b_conflict_cnt);
      end
      idle_inputs();
      edge_();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(99) < 2);
         src0_valid = $urandom_range(99) < 60;
         src1_valid = $urandom_range(99) < 60;
         src0_rd    = 5'($urandom_range(31));
         src1_rd    = 5'($urandom_range(31));
         src0_data  = $urandom;
         src1_data  = $urandom;
         half();
         vectors++;
         if (src0_ready !== exp_r0 || src1_ready !== exp_r1) begin
            miscompares++;
            $display("FAIL rand_ready[%0d]: got %b%b want %b%b",
                     i, src0_ready, src1_ready, exp_r0, exp_r1);
         end
         edge_();
         vectors++;
         if (we3 !== exp_we || a3 !== exp_a3 || wd3 !== exp_wd || grant_src !== exp_gs
             || conflict_cnt !== 16'(m_conf) || b_conflict_cnt !== 4'(m_conf4)) begin
            miscompares++;
            $display("FAIL rand_out[%0d]: got %b %0d %h %b %0d %0d want %b %0d %h %b %0d %0d",
                     i, we3, a3, wd3, grant_src, conflict_cnt, b_conflict_cnt,
                     exp_we, exp_a3, exp_wd, exp_gs, m_conf, m_conf4);
         end
      end
      reset = 0;
      idle_inputs();
      edge_();
   endtask

   initial begin
      m_wait = 0; m_conf = 0; m_conf4 = 0;
      exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_gs = 0; exp_r0 = 0; exp_r1 = 0;
      reset = 1;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_src0_only();
      test_src1_only();
      test_starvation();
      test_x0();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
